sha256_stream_ctrl: RTL and testbench
=====================================

Name: sha256_stream_ctrl

Overview:
Sequencing controller for the single-block sha256_compressor. It accepts a stream of pre-padded 512-bit blocks over a valid/ready handshake and drives the compressor's start/message_block/initial_hash/done handshake. It chains each block's hash_out into the next block's initial_hash and presents the final 256-bit digest on a valid/ready output. It sits between the host/padding front-end and the compressor instance.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in RUN waiting for comp_done before abort (>=2)
CNT_W, 16, width of processed-block counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
blk_valid  in  1  input block valid
blk_ready  out  1  controller can accept a block
blk_data  in  512  padded message block, word 0 in [511:480]
blk_first  in  1  block starts a new message (use IV)
blk_last  in  1  block ends the message
comp_start  out  1  to compressor start
comp_message  out  512  to compressor message_block
comp_init_hash  out  256  to compressor initial_hash
comp_hash  in  256  from compressor hash_out (includes feed-forward add)
comp_done  in  1  from compressor done
digest_valid  out  1  final digest available
digest_ready  in  1  consumer accepts digest
digest  out  256  final hash, H0 in [255:224]
busy  out  1  state != IDLE
error  out  1  sticky: timeout or sequence error
block_count  out  CNT_W  blocks completed in current message

Behaviour:
- Reset (async, rst_n=0): state=IDLE; blk_ready=1 after release; comp_start=0; comp_message=0; comp_init_hash=0; digest_valid=0; digest=0; chain register=0; chain_valid=0; error=0; block_count=0; watchdog=0.
- IV constant: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- States: IDLE, RUN, DRAIN, DIGEST.
- IDLE: blk_ready=1. On blk_valid&blk_ready: register blk_data into comp_message; comp_init_hash = (blk_first | !chain_valid) ? IV : chain; register last flag; if blk_first, block_count=0 and error cleared; if !blk_first & !chain_valid, set error (block still processed with IV). Next state RUN.
- RUN: comp_start=1 held continuously (compressor samples level); comp_message/comp_init_hash stable; watchdog increments each cycle. On comp_done=1: chain<=comp_hash, chain_valid=1, block_count+=1 (saturates at all-ones), comp_start<=0, watchdog=0, -> DRAIN. If watchdog reaches TIMEOUT_CYCLES-1 without comp_done: comp_start<=0, error=1, chain_valid=0, -> IDLE.
- DRAIN: comp_start=0; wait comp_done=0 (prevents re-triggering on level-held done); then last ? DIGEST : IDLE. chain_valid cleared when leaving for DIGEST.
- DIGEST: digest_valid=1, digest=chain, blk_ready=0. Held stable until digest_valid&digest_ready, then -> IDLE, digest_valid=0 next cycle.
- Latency per block: 1 cycle accept + compressor latency + 1 cycle DRAIN minimum; blk_ready low from accept until return to IDLE.
- blk_ready is 0 in RUN, DRAIN, DIGEST; no overlap of input and output handshakes.
- Reset mid-operation: all state returns to reset values immediately, compressor start dropped asynchronously; partial message discarded.
- block_count, chain are 256/CNT_W unsigned registers, no arithmetic beyond increment.

Decomposition:
- Shared package sha256_pkg: SHA256_IV 256-bit constant, state enum (IDLE/RUN/DRAIN/DIGEST), block/hash width constants (512, 256).
- No sub-module required; the watchdog is an inline counter. Bench instantiates this block with a real sha256_compressor plus a stub compressor for fault injection.

Test Plan:
- Single block "abc" (61626380, zeros, 00000018), first=last=1 -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, block_count=1, error=0.
- Two blocks "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded, first on blk 0, last on blk 1 -> digest=248d6a61d20638b8e5c026930c3e60 39a33ce45964ff2167f6ecedd419db06c1, block_count=2; second comp_init_hash equals first comp_hash.
- digest_ready held 0 for 20 cycles -> digest_valid and digest stable, blk_ready=0; release -> IDLE one cycle after handshake.
- Stub compressor never asserts done, TIMEOUT_CYCLES=8 -> comp_start drops after 8 RUN cycles, error=1, state IDLE; next blk_first block clears error and hashes "abc" correctly.
- Stub holds comp_done high 5 cycles -> exactly one block_count increment, no second start until done low.
- rst_n pulsed low 3 cycles into RUN -> comp_start=0, digest=0, block_count=0, blk_ready=1 after release; then "abc" hashes correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: standard initial hash value, datapath widths and
// the sequencing-controller state encoding.
package sha256_pkg;

  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;

  localparam logic [HASH_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    DIGEST = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/sha256_stream_ctrl.sv
// Block-stream sequencer for a single-block SHA-256 compressor: chains hash
// state across blocks, guards against a stuck compressor, presents the digest.
module sha256_stream_ctrl
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_first,
  input  logic               blk_last,
  output logic               comp_start,
  output logic [BLOCK_W-1:0] comp_message,
  output logic [HASH_W-1:0]  comp_init_hash,
  input  logic [HASH_W-1:0]  comp_hash,
  input  logic               comp_done,
  output logic               digest_valid,
  input  logic               digest_ready,
  output logic [HASH_W-1:0]  digest,
  output logic               busy,
  output logic               error,
  output logic [CNT_W-1:0]   block_count
);

  localparam int               WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e        state, state_next;
  logic [HASH_W-1:0]  chain;
  logic               chain_valid;
  logic               last_flag;
  logic [WD_W-1:0]    watchdog;

  logic accept, run_done, run_timeout, drain_exit;

  assign blk_ready    = (state == IDLE);
  assign digest_valid = (state == DIGEST);
  assign busy         = (state != IDLE);

  assign accept      = blk_valid & blk_ready;
  assign run_done    = (state == RUN) & comp_done;
  assign run_timeout = (state == RUN) & ~comp_done & (watchdog == WD_LAST);
  assign drain_exit  = (state == DRAIN) & ~comp_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state defaults to the current state before the case so no path
  // leaves state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)                    state_next = RUN;
      RUN:     if (run_done)                  state_next = DRAIN;
               else if (run_timeout)          state_next = IDLE;
      DRAIN:   if (drain_exit)                state_next = last_flag ? DIGEST : IDLE;
      DIGEST:  if (digest_ready)              state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_start     <= 1'b0;
      comp_message   <= '0;
      comp_init_hash <= '0;
      digest         <= '0;
      chain          <= '0;
      chain_valid    <= 1'b0;
      last_flag      <= 1'b0;
      error          <= 1'b0;
      block_count    <= '0;
      watchdog       <= '0;
    end else begin
      if (accept) begin
        comp_message   <= blk_data;
        comp_init_hash <= (blk_first || !chain_valid) ? SHA256_IV : chain;
        last_flag      <= blk_last;
        comp_start     <= 1'b1;
        watchdog       <= '0;
        if (blk_first) begin
          block_count <= '0;
          error       <= 1'b0;
        end else if (!chain_valid) begin
          // Continuation with no chained state: hash from IV but flag it.
          error <= 1'b1;
        end
      end

      if (run_done) begin
        chain       <= comp_hash;
        chain_valid <= 1'b1;
        comp_start  <= 1'b0;
        watchdog    <= '0;
        if (block_count != '1) block_count <= block_count + 1'b1;
      end else if (run_timeout) begin
        comp_start  <= 1'b0;
        error       <= 1'b1;
        chain_valid <= 1'b0;
        watchdog    <= '0;
      end else if (state == RUN) begin
        watchdog <= watchdog + 1'b1;
      end

      if (drain_exit && last_flag) begin
        digest      <= chain;
        chain_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Scoreboard bench: a behavioural compressor answers the controller, while a
// monitor compares each presented digest against the reference SHA-256 model.
module tb_sha256_stream_ctrl;
  import sha256_pkg::*;

  localparam int CNT_W = 16;
  localparam int TO    = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               blk_valid = 1'b0;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data = '0;
  logic               blk_first = 1'b0;
  logic               blk_last = 1'b0;
  logic               comp_start;
  logic [BLOCK_W-1:0] comp_message;
  logic [HASH_W-1:0]  comp_init_hash;
  logic [HASH_W-1:0]  comp_hash;
  logic               comp_done;
  logic               digest_valid;
  logic               digest_ready = 1'b1;
  logic [HASH_W-1:0]  digest;
  logic               busy;
  logic               error;
  logic [CNT_W-1:0]   block_count;

  sha256_stream_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last),
    .comp_start(comp_start), .comp_message(comp_message),
    .comp_init_hash(comp_init_hash), .comp_hash(comp_hash), .comp_done(comp_done),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
    .busy(busy), .error(error), .block_count(block_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression including the feed-forward add.
  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2, ch, maj;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1  = v[7] + s1 + ch + K[i] + w[i];
      s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2  = s0 + maj;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return r;
  endfunction

  typedef enum int {CM_NORMAL, CM_HANG, CM_HOLD5} cmode_e;
  typedef struct { logic [511:0] m; logic [255:0] ih; } cmp_t;
  typedef struct { logic [255:0] d; logic [CNT_W-1:0] cnt; logic err; } dig_t;

  cmode_e cmode = CM_NORMAL;
  cmp_t   exp_comp[$];
  dig_t   exp_q[$];
  logic [511:0] msg_q[$];

  int total = 0, bad = 0;
  int n_starts = 0, start_during_done = 0;
  int ready_mode = 0;
  int exp_cnt = 0;
  bit exp_err = 1'b0, chain_ok = 1'b0;
  logic [255:0] chain_model = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural compressor: latches message/IV on start, answers after a short
  // random latency and holds done for a few cycles.
  initial begin
    cmp_t e;
    logic [511:0] cm;
    logic [255:0] ci;
    int lat, hold;
    bit aborted;
    comp_done = 1'b0;
    comp_hash = '0;
    forever begin
      @(negedge clk);
      if (rst_n && comp_start && !comp_done) begin
        n_starts++;
        cm = comp_message;
        ci = comp_init_hash;
        check("comp_pending", exp_comp.size() != 0, 1);
        if (exp_comp.size() != 0) begin
          e = exp_comp.pop_front();
          check("comp_message", cm, e.m);
          check("comp_init_hash", ci, e.ih);
        end
        lat = (cmode == CM_HANG) ? 1000 : $urandom_range(1, 5);
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n || !comp_start) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
          comp_hash = sha_compress(ci, cm);
          comp_done = 1'b1;
          hold = (cmode == CM_HOLD5) ? 5 : $urandom_range(1, 3);
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rst_n) break;
            if (comp_start) start_during_done++;
          end
          comp_done = 1'b0;
        end
      end
    end
  end

  // Consumer back-pressure, overridden by directed tests through ready_mode.
  initial forever begin
    @(negedge clk);
    if (ready_mode == 0) digest_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples just after the falling edge, ahead of the handshake edge.
  initial begin
    dig_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && digest_valid && digest_ready) begin
        check("digest_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("digest", digest, e.d);
          check("block_count", block_count, e.cnt);
          check("error_at_digest", error, e.err);
        end
      end
    end
  end

  task automatic send_block(input logic [511:0] d, input bit f, input bit l);
    int w = 0;
    @(negedge clk);
    while (!blk_ready && w < 300) begin @(negedge clk); w++; end
    if (!blk_ready) begin
      check("blk_ready_wait", blk_ready, 1);
      return;
    end
    blk_valid = 1'b1; blk_data = d; blk_first = f; blk_last = l;
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // Sends msg_q as one message; expectations come from folding the reference
  // compression over the blocks (or from a published digest when given).
  task automatic send_msg(input bit first0, input bit use_want, input logic [255:0] want);
    logic [255:0] h;
    int n = msg_q.size();
    dig_t dg;
    if (first0) begin exp_cnt = 0; exp_err = 1'b0; end
    else if (!chain_ok) exp_err = 1'b1;
    h = (first0 || !chain_ok) ? SHA256_IV : chain_model;
    for (int i = 0; i < n; i++) begin
      exp_comp.push_back('{m: msg_q[i], ih: h});
      h = sha_compress(h, msg_q[i]);
      exp_cnt++;
    end
    dg.d = use_want ? want : h;
    dg.cnt = CNT_W'(exp_cnt);
    dg.err = exp_err;
    exp_q.push_back(dg);
    chain_ok = 1'b0;
    for (int i = 0; i < n; i++) send_block(msg_q[i], first0 && (i == 0), i == n - 1);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 500) begin @(negedge clk); w++; end
    check("wait_idle_bound", w < 500, 1);
  endtask

  logic [511:0] abc_blk, two0, two1, rnd;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    int cnt, s0, stable_bad, w;
    logic [255:0] held;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    two0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two1 = {480'h0, 32'h000001c0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_blk_ready", blk_ready, 1);
    check("rst_comp_start", comp_start, 0);
    check("rst_comp_message", comp_message, 0);
    check("rst_comp_init_hash", comp_init_hash, 0);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_block_count", block_count, 0);

    // Published vectors: one-block "abc" and the two-block message.
    msg_q = '{abc_blk};
    send_msg(1'b1, 1'b1, ABC_DIG);
    wait_idle();
    msg_q = '{two0, two1};
    send_msg(1'b1, 1'b1, TWO_DIG);
    wait_idle();

    // Random multi-block messages.
    for (int k = 0; k < 6; k++) begin
      msg_q.delete();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        for (int j = 0; j < 16; j++) rnd[511-32*j -: 32] = $urandom;
        msg_q.push_back(rnd);
      end
      send_msg(1'b1, 1'b0, '0);
    end
    wait_idle();

    // Continuation block with no chained state: hashed from IV, error flagged.
    for (int j = 0; j < 16; j++) rnd[511-32*j -: 32] = $urandom;
    msg_q = '{rnd};
    send_msg(1'b0, 1'b0, '0);
    wait_idle();

    // Consumer stall: digest held stable with input side blocked.
    ready_mode = 1;
    digest_ready = 1'b0;
    msg_q = '{abc_blk};
    send_msg(1'b1, 1'b1, ABC_DIG);
    w = 0;
    while (!digest_valid && w < 100) begin @(negedge clk); w++; end
    check("stall_digest_valid", digest_valid, 1);
    held = digest;
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!digest_valid || digest !== held || blk_ready) stable_bad++;
    end
    check("stall_stable", stable_bad, 0);
    ready_mode = 2;
    digest_ready = 1'b1;
    @(negedge clk);
    check("post_hs_digest_valid", digest_valid, 0);
    check("post_hs_busy", busy, 0);
    ready_mode = 0;

    // Stuck compressor: watchdog aborts after TO cycles of RUN.
    cmode = CM_HANG;
    exp_comp.push_back('{m: abc_blk, ih: SHA256_IV});
    exp_cnt = 0; exp_err = 1'b1; chain_ok = 1'b0;
    send_block(abc_blk, 1'b1, 1'b1);
    cnt = 0;
    while (comp_start && cnt < 100) begin cnt++; @(negedge clk); end
    check("timeout_run_cycles", cnt, TO);
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    check("timeout_blk_ready", blk_ready, 1);
    cmode = CM_NORMAL;
    msg_q = '{abc_blk};
    send_msg(1'b1, 1'b1, ABC_DIG);
    wait_idle();

    // Level-held done: exactly one start and one count increment.
    cmode = CM_HOLD5;
    s0 = n_starts;
    msg_q = '{abc_blk};
    send_msg(1'b1, 1'b1, ABC_DIG);
    wait_idle();
    check("hold5_starts", n_starts - s0, 1);
    cmode = CM_NORMAL;

    // Reset three cycles into RUN discards the message.
    cmode = CM_HANG;
    exp_comp.push_back('{m: abc_blk, ih: SHA256_IV});
    send_block(abc_blk, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_comp_start", comp_start, 0);
    check("midrst_digest", digest, 0);
    check("midrst_block_count", block_count, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0; exp_err = 1'b0; chain_ok = 1'b0;
    cmode = CM_NORMAL;
    @(negedge clk);
    check("midrst_blk_ready", blk_ready, 1);
    check("midrst_error", error, 0);
    msg_q = '{abc_blk};
    send_msg(1'b1, 1'b1, ABC_DIG);
    wait_idle();

    check("digest_queue_empty", exp_q.size(), 0);
    check("comp_queue_empty", exp_comp.size(), 0);
    check("start_while_done", start_during_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
